// File: rtl/tt_um_serial_adder_seq.sv
// Bit-serial adder sequencer: one full-adder slice (two half-adders plus OR)
// steps through the operands LSB first and publishes the sum with busy/done.
module tt_um_serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               co_q, co_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               load_a, load_b, start, load_any;
  logic               bit_h, bit_s, bit_c;
  logic [WIDTH:0]     s_cat;
  logic [7:0]         r_ext;
  logic               unused_inputs;

  assign load_a   = uio_in[0];
  assign load_b   = uio_in[1];
  assign start    = uio_in[2];
  assign load_any = load_a | load_b;

  // One full-adder step built from the half-adder pair.
  assign bit_h = sa_q[0] ^ sb_q[0];
  assign bit_s = bit_h ^ c_q;
  assign bit_c = (sa_q[0] & sb_q[0]) | (bit_h & c_q);
  assign s_cat = {bit_s, s_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    c_d     = c_q;
    s_d     = s_q;
    r_d     = r_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (ena) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (load_a) a_d = ui_in[WIDTH-1:0];
          if (load_b) b_d = ui_in[WIDTH-1:0];
          // A load always beats a start in the same cycle.
          if (load_any) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end else if (start) begin
            state_d = ST_RUN;
            sa_d    = a_q;
            sb_d    = b_q;
            c_d     = 1'b0;
            s_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        ST_RUN: begin
          c_d   = bit_c;
          s_d   = s_cat[WIDTH:1];
          sa_d  = sa_q >> 1;
          sb_d  = sb_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_DONE;
            r_d     = s_cat[WIDTH:1];
            co_d    = bit_c;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      c_q     <= c_d;
      s_q     <= s_d;
      r_q     <= r_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    r_ext            = '0;
    r_ext[WIDTH-1:0] = r_q;
  end

  assign uo_out  = r_ext;
  assign uio_out = {busy_q, done_q, co_q, 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

  assign unused_inputs = &{1'b0, ui_in, uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_serial_adder_seq.sv
// Bench for the serial adder sequencer: vector table, corner-case sequences
// and randomized operands checked against plain integer addition.
module tb_tt_um_serial_adder_seq;

  localparam int WIDTH = 8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_errors;

  logic [7:0] m_a;
  logic [7:0] m_b;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_co;
  } vec_t;

  vec_t vecs[6];

  tt_um_serial_adder_seq #(.WIDTH(WIDTH)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    ui_in  = a;
    uio_in = 8'h01;
    step();
    ui_in  = b;
    uio_in = 8'h02;
    step();
    uio_in = 8'h00;
    ui_in  = 8'h00;
    m_a = a;
    m_b = b;
  endtask

  task automatic start_op();
    uio_in = 8'h04;
    step();
    uio_in = 8'h00;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (uio_out[7] && cyc < 64) begin
      cyc++;
      step();
    end
  endtask

  task automatic check_result(input string tag);
    logic [8:0] sum9;
    sum9 = {1'b0, m_a} + {1'b0, m_b};
    check({tag, " done"}, uio_out[6], 1'b1);
    check({tag, " sum"}, uo_out, sum9[7:0]);
    check({tag, " carry"}, uio_out[5], sum9[8]);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    int cyc;
    load_ab(a, b);
    start_op();
    check({tag, " busy after start"}, uio_out[7], 1'b1);
    wait_done(cyc);
    check({tag, " busy cycles"}, cyc, WIDTH);
    check_result(tag);
  endtask

  initial begin
    int cyc;
    bit done_low_ok;

    n_checks = 0;
    n_errors = 0;
    m_a = 8'h00;
    m_b = 8'h00;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b0;

    vecs[0] = '{8'h35, 8'h4A, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[3] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};

    // Reset state
    #12;
    check("reset uo_out", uo_out, 8'h00);
    check("reset uio_out", uio_out, 8'h00);
    check("reset uio_oe", uio_oe, 8'hE0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Vector table
    foreach (vecs[i]) begin
      load_ab(vecs[i].a, vecs[i].b);
      start_op();
      check("vec busy after start", uio_out[7], 1'b1);
      wait_done(cyc);
      check("vec busy cycles", cyc, WIDTH);
      check("vec done", uio_out[6], 1'b1);
      check("vec sum", uo_out, vecs[i].exp_sum);
      check("vec carry", uio_out[5], vecs[i].exp_co);
      check("vec low uio_out", uio_out[4:0], 5'd0);
    end

    // Load and start during RUN are ignored
    load_ab(8'h35, 8'h4A);
    start_op();
    cyc = 0;
    for (int i = 0; i < 64 && uio_out[7]; i++) begin
      if (i == 2) begin
        uio_in = 8'h05;
        ui_in  = 8'h00;
      end else begin
        uio_in = 8'h00;
      end
      cyc++;
      step();
    end
    uio_in = 8'h00;
    check("inject busy cycles", cyc, WIDTH);
    check_result("inject");

    // ena low mid-RUN freezes everything
    start_op();
    cyc = 0;
    done_low_ok = 1'b1;
    for (int i = 0; i < 64 && uio_out[7]; i++) begin
      ena = !(i >= 3 && i < 8);
      if (i > 3 && i <= 8 && uio_out[6] !== 1'b0) done_low_ok = 1'b0;
      cyc++;
      step();
    end
    ena = 1'b1;
    check("ena hold done low", done_low_ok, 1'b1);
    check("ena busy cycles", cyc, WIDTH + 5);
    check_result("ena");

    // ena low in IDLE blocks loads and starts
    ena    = 1'b0;
    ui_in  = 8'hFF;
    uio_in = 8'h05;
    step();
    step();
    ena    = 1'b1;
    uio_in = 8'h00;
    check("ena idle busy", uio_out[7], 1'b0);
    check("ena idle done held", uio_out[6], 1'b1);
    start_op();
    wait_done(cyc);
    check("ena idle busy cycles", cyc, WIDTH);
    check_result("ena idle");

    // Reset mid-RUN
    load_ab(8'h35, 8'h4A);
    start_op();
    repeat (4) step();
    check("pre-reset busy", uio_out[7], 1'b1);
    rst_n = 1'b0;
    #2;
    check("mid reset uo_out", uo_out, 8'h00);
    check("mid reset uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    m_a = 8'h00;
    m_b = 8'h00;
    step();
    check("post reset uio_out", uio_out, 8'h00);
    start_op();
    wait_done(cyc);
    check("post reset busy cycles", cyc, WIDTH);
    check_result("post reset zero");
    run_op("post reset fresh", 8'h12, 8'h34);

    // start held high re-triggers after DONE
    load_ab(8'h01, 8'h02);
    uio_in = 8'h04;
    step();
    wait_done(cyc);
    check("hold run1 cycles", cyc, WIDTH);
    check_result("hold run1");
    step();
    check("hold retrigger busy", uio_out[7], 1'b1);
    check("hold retrigger done", uio_out[6], 1'b0);
    wait_done(cyc);
    check("hold run2 cycles", cyc, WIDTH);
    check_result("hold run2");
    ui_in  = 8'h10;
    uio_in = 8'h06;
    step();
    m_b = 8'h10;
    check("load wins done", uio_out[6], 1'b0);
    check("load wins busy", uio_out[7], 1'b0);
    check("load wins sum held", uo_out, 8'h03);
    uio_in = 8'h00;
    step();
    check("load wins idle", uio_out[7], 1'b0);
    start_op();
    wait_done(cyc);
    check("after load cycles", cyc, WIDTH);
    check("after load sum", uo_out, 8'h11);
    check_result("after load");

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        ui_in  = ra;
        uio_in = 8'h03;
        step();
        uio_in = 8'h00;
        m_a = ra;
        m_b = ra;
        start_op();
        wait_done(cyc);
        check("rand both busy cycles", cyc, WIDTH);
        check_result("rand both");
      end else begin
        run_op("rand", ra, rb);
      end
    end

    check("final uio_oe", uio_oe, 8'hE0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tt_um_serial_adder_seq.md
Name: tt_um_serial_adder_seq

Overview:
- Bit-serial add sequencer built around the half-adder cell (XOR sum / AND carry), packaged as a standard tt_um_ top-level.
- Captures two operands over the dedicated inputs and drives the half-adder pair as a full adder, one bit per clock, LSB first.
- Presents the sum and carry-out with a busy/done handshake.
- Replaces the purely combinational 1-bit add with a sequenced multi-bit add that reuses one adder slice.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..8; bits above WIDTH-1 of ui_in are ignored and uo_out[7:WIDTH] read 0.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  design enable; when 0 all state holds (no loads, no starts, no bit steps)
ui_in  input  8  operand data bus, sampled on load strobes
uio_in  input  8  [0]=load_a, [1]=load_b, [2]=start, [7:3] unused
uo_out  output  8  last completed sum (sum[WIDTH-1:0], upper bits 0)
uio_out  output  8  [7]=busy, [6]=done, [5]=carry_out, [4:0]=0
uio_oe  output  8  constant 8'b1110_0000

Behaviour:
- One clock clk; reset rst_n asynchronous active-low. While rst_n=0: state=IDLE, A=B=0, shift/sum/carry regs=0, uo_out=0, busy=0, done=0, carry_out=0. uio_oe is constant, also during reset.
- All control inputs are sampled on the rising edge and are level-sensitive. No edge detection: start held high re-triggers after DONE.
- Registers:
  - A, B: WIDTH-bit operand regs.
  - SA, SB: working shift regs.
  - C: 1-bit carry.
  - S: shift-in sum reg.
  - R: WIDTH-bit result reg, drives uo_out.
  - CO: carry_out reg.
  - cnt: bit counter, $clog2(WIDTH+1) bits.
- Loads:
  - load_a=1 in IDLE or DONE: A<=ui_in[WIDTH-1:0].
  - load_b=1 in IDLE or DONE: B<=ui_in[WIDTH-1:0].
  - Both asserted together: both load the same value.
  - Loads are ignored in RUN.
  - Any load in DONE clears done to 0 and moves to IDLE. R and CO hold.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN: start=1, no load strobe that cycle, ena=1. Loads win over start in the same cycle; start is then ignored.
  - On entry to RUN: SA<=A, SB<=B, C<=0, cnt<=0, busy<=1, done<=0.
  - RUN, each edge, bit i = cnt:
    - h = SA[0]^SB[0]
    - s = h^C
    - C <= (SA[0]&SB[0]) | (h&C), i.e. two half-adders plus OR.
    - S <= {s, S[WIDTH-1:1]}
    - SA, SB shift right by 1.
    - cnt <= cnt+1.
  - RUN -> DONE: on the edge processing bit WIDTH-1. Same edge: R<=final sum, CO<=final carry, busy<=0, done<=1.
  - DONE: R, CO and done hold until the next start or load.
  - start in RUN: ignored.
- Latency: start sampled at edge k -> busy=1 after edge k -> done=1 and uo_out/carry_out valid after edge k+WIDTH. Busy is high for exactly WIDTH cycles.
- Back-to-back: start held in DONE begins a new op on the next edge using the current A/B. Busy returns one cycle after done.
- uo_out and carry_out never show partial results; they update only on RUN->DONE.
- ena=0: every register holds, in any state, including mid-RUN. Resumes exactly where it stopped when ena returns to 1.
- Reset mid-RUN: immediate return to all-zero IDLE; the partial result is discarded.
- Arithmetic: unsigned, modulo 2^WIDTH. carry_out = bit WIDTH of A+B.

Test Plan:
- Reset, then load_a with ui_in=0x35, load_b with ui_in=0x4A, start -> busy for 8 cycles, then done=1, uo_out=0x7F, carry_out=0.
- A=0xFF, B=0x01, start -> after 8 cycles uo_out=0x00, carry_out=1. Then A=0x80, B=0x80 -> uo_out=0x00, carry_out=1. Then A=0xAA, B=0x55 -> uo_out=0xFF, carry_out=0.
- During RUN of 0x35+0x4A, pulse start and load_a with ui_in=0x00 at cycle 3 -> no effect: result still 0x7F, busy still exactly 8 cycles.
- Drop ena at RUN cycle 4 for 5 cycles -> busy holds and done stays low. Result 0x7F appears 8 enabled cycles after start.
- Assert rst_n=0 at RUN cycle 5 -> immediately busy=0, done=0, uo_out=0, carry_out=0. After release: state IDLE and a fresh op works.
- Hold start high with A=0x01, B=0x02 -> done pulses after each 8-cycle run, with uo_out=0x03. Assert load_b=0x10 with start while in DONE -> load wins, done=0, IDLE. Next start gives 0x11.
